vga_stripe_gen: RTL and testbench

Pixel-colour stage that sits directly downstream of the `vga` timing generator. Consumes its horizontal/vertical counters and sync pulses, and produces an 8-bit RGB332 pixel plus syncs re-timed to match. Generates four test patterns: vertical bars, horizontal bars, checkerboard, and scrolling bars. The pattern mode is latched once per frame, so a mode change never tears an image.

---
 rtl/vga_stripe_gen.sv | 129 ++++++++++++
 tb/tb_vga_stripe_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_stripe_gen.sv
// Pixel-colour stage behind the vga timing generator: turns hc/vc into an RGB332
// test pattern with syncs re-timed through the same two-register pipeline.
module vga_stripe_gen #(
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int STRIPE_LOG2 = 6,
  parameter int SCROLL_STEP = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] hc,
  input  logic [15:0] vc,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic        vidon,
  output logic [7:0]  rgb
);

  localparam logic [15:0] HBP_W  = 16'(HBP);
  localparam logic [15:0] HFP_W  = 16'(HFP);
  localparam logic [15:0] VBP_W  = 16'(VBP);
  localparam logic [15:0] VFP_W  = 16'(VFP);
  localparam logic [15:0] STEP_W = 16'(SCROLL_STEP);

  // Stage 1 registers
  logic        act1_q, act1_d;
  logic [15:0] x1_q, x1_d;
  logic [15:0] y1_q, y1_d;
  logic        hs1_q, vs1_q;

  // Stage 2 registers (drive the ports directly)
  logic        hs2_q, vs2_q;
  logic        vidon_q;
  logic [7:0]  rgb_q, rgb_d;

  // Frame-rate state
  logic        vs_q;
  logic        frame_start;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  mode_q, mode_d;

  logic [15:0] scroll;
  logic [15:0] xs;
  logic [2:0]  idx;
  logic [7:0]  pix;
  logic        unused_bits;

  assign act1_d = (hc >= HBP_W) && (hc < HFP_W) && (vc >= VBP_W) && (vc < VFP_W);
  assign x1_d   = hc - HBP_W;
  assign y1_d   = vc - VBP_W;

  // A falling vsync_i edge marks the start of a new frame.
  assign frame_start = vs_q & ~vsync_i;
  assign frame_cnt_d = frame_start ? frame_cnt_q + 10'd1 : frame_cnt_q;
  assign mode_d      = frame_start ? mode : mode_q;

  assign scroll = {6'd0, frame_cnt_q} * STEP_W;
  assign xs     = x1_q + scroll;

  always_comb begin
    idx = 3'd0;
    case (mode_q)
      2'd0:    idx = x1_q[STRIPE_LOG2 +: 3];
      2'd1:    idx = y1_q[STRIPE_LOG2 +: 3];
      2'd2:    idx = (x1_q[STRIPE_LOG2] ^ y1_q[STRIPE_LOG2]) ? 3'd7 : 3'd0;
      default: idx = xs[STRIPE_LOG2 +: 3];
    endcase
  end

  always_comb begin
    pix = 8'h00;
    case (idx)
      3'd0:    pix = 8'hFF;
      3'd1:    pix = 8'hFC;
      3'd2:    pix = 8'h1F;
      3'd3:    pix = 8'h1C;
      3'd4:    pix = 8'hE3;
      3'd5:    pix = 8'hE0;
      3'd6:    pix = 8'h03;
      default: pix = 8'h00;
    endcase
  end

  assign rgb_d = act1_q ? pix : 8'h00;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      act1_q      <= 1'b0;
      x1_q        <= 16'd0;
      y1_q        <= 16'd0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      vidon_q     <= 1'b0;
      rgb_q       <= 8'h00;
      vs_q        <= 1'b1;
      frame_cnt_q <= 10'd0;
      mode_q      <= 2'd0;
    end else begin
      act1_q      <= act1_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      hs1_q       <= hsync_i;
      vs1_q       <= vsync_i;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      vidon_q     <= act1_q;
      rgb_q       <= rgb_d;
      vs_q        <= vsync_i;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign vidon = vidon_q;
  assign rgb   = rgb_q;

  // Only the stripe-index bits of the coordinate vectors feed the pattern.
  assign unused_bits = ^{x1_q, y1_q, xs};

endmodule

// File: tb/tb_vga_stripe_gen.sv
// Directed bench for vga_stripe_gen: reset, bar/checker/scroll patterns, sync
// alignment, per-frame mode latching and asynchronous clear.
`timescale 1ns/1ps
module tb_vga_stripe_gen;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] hc = 16'd0;
  logic [15:0] vc = 16'd0;
  logic        hsync_i = 1'b1;
  logic        vsync_i = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        hsync, vsync, vidon;
  logic [7:0]  rgb;

  int n_checks = 0;
  int n_fail   = 0;

  vga_stripe_gen dut (
    .clk     (clk),
    .clr     (clr),
    .hc      (hc),
    .vc      (vc),
    .hsync_i (hsync_i),
    .vsync_i (vsync_i),
    .mode    (mode),
    .hsync   (hsync),
    .vsync   (vsync),
    .vidon   (vidon),
    .rgb     (rgb)
  );

  // 80 MHz pixel clock
  always #6.25 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold one coordinate long enough to flush both pipeline stages, then compare.
  task automatic pix(input string tag, input logic [15:0] h, input logic [15:0] v,
                     input logic [7:0] exp_rgb, input logic exp_vid);
    hc = h;
    vc = v;
    step();
    step();
    check_eq(tag, {24'd0, rgb}, {24'd0, exp_rgb});
    check_eq({tag, "_vidon"}, {31'd0, vidon}, {31'd0, exp_vid});
  endtask

  // One vsync_i falling edge; the mode is presented in the same cycle as the edge.
  task automatic frame(input logic [1:0] m);
    mode    = m;
    vsync_i = 1'b0;
    step();
    vsync_i = 1'b1;
    step();
  endtask

  task automatic pulse_reset();
    clr = 1'b0;
    #2;
    clr = 1'b1;
    step();
  endtask

  initial begin
    int first_low;
    int width;
    logic [7:0] exp_rgb;

    // Reset held with random inputs
    #3 clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hc      = 16'($urandom_range(0, 799));
      vc      = 16'($urandom_range(0, 520));
      hsync_i = 1'($urandom_range(0, 1));
      vsync_i = 1'($urandom_range(0, 1));
      mode    = 2'($urandom_range(0, 3));
      step();
      check_eq("rst_rgb",   {24'd0, rgb},   32'h00);
      check_eq("rst_vidon", {31'd0, vidon}, 32'd0);
      check_eq("rst_hsync", {31'd0, hsync}, 32'd1);
      check_eq("rst_vsync", {31'd0, vsync}, 32'd1);
    end
    hc = 16'd0; vc = 16'd0; hsync_i = 1'b1; vsync_i = 1'b1; mode = 2'd0;
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_rst_rgb",   {24'd0, rgb},   32'h00);
      check_eq("post_rst_vidon", {31'd0, vidon}, 32'd0);
      check_eq("post_rst_hsync", {31'd0, hsync}, 32'd1);
    end

    // Mode 0 streaming sweep: output lags the input by two edges
    vc = 16'd100;
    for (int h = 142; h <= 211; h++) begin
      hc = 16'(h);
      step();
      if (h > 142) begin
        if (h - 1 < 144)      exp_rgb = 8'h00;
        else if (h - 1 < 208) exp_rgb = 8'hFF;
        else                  exp_rgb = 8'hFC;
        check_eq("m0_sweep_rgb", {24'd0, rgb}, {24'd0, exp_rgb});
        check_eq("m0_sweep_vidon", {31'd0, vidon}, (h - 1 >= 144) ? 32'd1 : 32'd0);
      end
    end
    pix("m0_hfp",   16'd784, 16'd100, 8'h00, 1'b0);
    pix("m0_vfp",   16'd200, 16'd511, 8'h00, 1'b0);
    pix("m0_bar8",  16'd656, 16'd100, 8'hFF, 1'b1);

    // hsync alignment: 96-cycle pulse driven in iterations 10..105
    hc = 16'd0; vc = 16'd0;
    first_low = -1; width = 0;
    for (int c = 0; c < 130; c++) begin
      hsync_i = (c >= 10 && c < 106) ? 1'b0 : 1'b1;
      step();
      if (hsync == 1'b0) begin
        if (first_low < 0) first_low = c;
        width++;
      end
    end
    check_eq("hsync_delay", 32'(first_low), 32'd11);
    check_eq("hsync_width", 32'(width), 32'd96);

    first_low = -1; width = 0;
    for (int c = 0; c < 130; c++) begin
      vsync_i = (c >= 10 && c < 106) ? 1'b0 : 1'b1;
      step();
      if (vsync == 1'b0) begin
        if (first_low < 0) first_low = c;
        width++;
      end
    end
    check_eq("vsync_delay", 32'(first_low), 32'd11);
    check_eq("vsync_width", 32'(width), 32'd96);

    // Mid-frame mode request has no effect until the next frame
    mode = 2'd1;
    pix("latch_hold", 16'd208, 16'd31, 8'hFC, 1'b1);
    frame(2'd1);
    pix("latch_m1_row1", 16'd144, 16'd95, 8'hFC, 1'b1);
    pix("latch_m1_row0", 16'd208, 16'd31, 8'hFF, 1'b1);

    // Checkerboard
    frame(2'd2);
    pix("chk_00", 16'd144, 16'd31, 8'hFF, 1'b1);
    pix("chk_10", 16'd208, 16'd31, 8'h00, 1'b1);
    pix("chk_11", 16'd208, 16'd95, 8'hFF, 1'b1);
    pix("chk_01", 16'd144, 16'd95, 8'h00, 1'b1);

    // Scrolling: 1024 frames after reset wraps frame_cnt back to 0
    pulse_reset();
    for (int i = 0; i < 1024; i++) frame(2'd3);
    pix("scr_f0_63", 16'd207, 16'd100, 8'hFF, 1'b1);
    pix("scr_f0_0",  16'd144, 16'd100, 8'hFF, 1'b1);
    frame(2'd3);
    pix("scr_f1_63", 16'd207, 16'd100, 8'hFC, 1'b1);
    pix("scr_f1_62", 16'd206, 16'd100, 8'hFF, 1'b1);

    // Asynchronous clear mid-frame, checked before any clock edge
    clr = 1'b0;
    #1;
    check_eq("aclr_rgb",   {24'd0, rgb},   32'h00);
    check_eq("aclr_vidon", {31'd0, vidon}, 32'd0);
    check_eq("aclr_hsync", {31'd0, hsync}, 32'd1);
    #1 clr = 1'b1;
    step();
    mode = 2'd3;
    pix("aclr_mode0", 16'd208, 16'd31, 8'hFC, 1'b1);
    frame(2'd3);
    pix("aclr_cnt1_62", 16'd206, 16'd100, 8'hFF, 1'b1);
    pix("aclr_cnt1_63", 16'd207, 16'd100, 8'hFC, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
